// File: rtl/mu01_prog_loader.sv
// mu01_prog_loader
// Receives a framed program image over a valid/ready byte stream, assembles
// big-endian 16-bit words and writes them into the mu01 core memory. The
// core is held in reset until the whole frame is in and its 8-bit checksum
// sums to zero. Frame: HEADER ADDR_H ADDR_L CNT_H CNT_L {HI LO}*CNT CSUM.
module mu01_prog_loader #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ADDR_H = 4'd1,
        ST_ADDR_L = 4'd2,
        ST_CNT_H  = 4'd3,
        ST_CNT_L  = 4'd4,
        ST_DATA_H = 4'd5,
        ST_DATA_L = 4'd6,
        ST_WRITE  = 4'd7,
        ST_CSUM   = 4'd8,
        ST_DONE   = 4'd9,
        ST_ERROR  = 4'd10
    } state_t;

    localparam logic [31:0] TIMEOUT_LIMIT   = TIMEOUT_CYCLES;
    localparam logic        TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] MAX_WORDS       = 16'd4096;

    // Running 8-bit modular checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t        state_r;
    state_t        state_next_s;

    logic [7:0]    acc_r;
    logic [11:0]   addr_r;
    logic [12:0]   count_r;
    logic [7:0]    cnt_h_r;
    logic [7:0]    hi_r;
    logic [31:0]   idle_cnt_r;

    logic          in_ready_r;
    logic          mem_we_r;
    logic [11:0]   mem_addr_r;
    logic [15:0]   mem_wdata_r;
    logic          cpu_reset_r;
    logic          done_r;
    logic          error_r;

    logic          take_s;
    logic          is_header_s;
    logic [7:0]    acc_sum_s;
    logic [15:0]   count_in_s;
    logic          timed_s;
    logic          timeout_hit_s;

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_reset = cpu_reset_r;
    assign done      = done_r;
    assign error     = error_r;

    // Handshake decode, checksum preview and idle-timeout detection.
    always_comb begin
        take_s      = in_valid && in_ready_r;
        is_header_s = (in_data == HEADER_BYTE);
        acc_sum_s   = csum_add(acc_r, in_data);
        count_in_s  = {cnt_h_r, in_data};
        case (state_r)
            ST_ADDR_H, ST_ADDR_L, ST_CNT_H, ST_CNT_L,
            ST_DATA_H, ST_DATA_L, ST_CSUM: timed_s = 1'b1;
            default:                       timed_s = 1'b0;
        endcase
        if (TIMEOUT_ENABLED && timed_s && !take_s) begin
            timeout_hit_s = (idle_cnt_r == (TIMEOUT_LIMIT - 32'd1));
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state logic; an accepted byte always wins over a timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (take_s && is_header_s) begin
                    state_next_s = ST_ADDR_H;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_ADDR_H: begin
                if (take_s)             state_next_s = ST_ADDR_L;
                else if (timeout_hit_s) state_next_s = ST_ERROR;
                else                    state_next_s = state_r;
            end
            ST_ADDR_L: begin
                if (take_s)             state_next_s = ST_CNT_H;
                else if (timeout_hit_s) state_next_s = ST_ERROR;
                else                    state_next_s = state_r;
            end
            ST_CNT_H: begin
                if (take_s)             state_next_s = ST_CNT_L;
                else if (timeout_hit_s) state_next_s = ST_ERROR;
                else                    state_next_s = state_r;
            end
            ST_CNT_L: begin
                if (take_s) begin
                    if (count_in_s > MAX_WORDS)      state_next_s = ST_ERROR;
                    else if (count_in_s == 16'd0)    state_next_s = ST_CSUM;
                    else                             state_next_s = ST_DATA_H;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DATA_H: begin
                if (take_s)             state_next_s = ST_DATA_L;
                else if (timeout_hit_s) state_next_s = ST_ERROR;
                else                    state_next_s = state_r;
            end
            ST_DATA_L: begin
                if (take_s)             state_next_s = ST_WRITE;
                else if (timeout_hit_s) state_next_s = ST_ERROR;
                else                    state_next_s = state_r;
            end
            ST_WRITE: begin
                // count_r still includes the word being written here
                if (count_r == 13'd1) state_next_s = ST_CSUM;
                else                  state_next_s = ST_DATA_H;
            end
            ST_CSUM: begin
                if (take_s) begin
                    if (acc_sum_s == 8'h00) state_next_s = ST_DONE;
                    else                    state_next_s = ST_ERROR;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame datapath: checksum, start address, word count, high byte latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= 8'h00;
            addr_r  <= 12'h000;
            count_r <= 13'd0;
            cnt_h_r <= 8'h00;
            hi_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (take_s && is_header_s) acc_r <= 8'h00;
                end
                ST_ADDR_H: begin
                    if (take_s) begin
                        acc_r        <= acc_sum_s;
                        addr_r[11:8] <= in_data[3:0];
                    end
                end
                ST_ADDR_L: begin
                    if (take_s) begin
                        acc_r       <= acc_sum_s;
                        addr_r[7:0] <= in_data;
                    end
                end
                ST_CNT_H: begin
                    if (take_s) begin
                        acc_r   <= acc_sum_s;
                        cnt_h_r <= in_data;
                    end
                end
                ST_CNT_L: begin
                    if (take_s) begin
                        acc_r   <= acc_sum_s;
                        count_r <= count_in_s[12:0];
                    end
                end
                ST_DATA_H: begin
                    if (take_s) begin
                        acc_r <= acc_sum_s;
                        hi_r  <= in_data;
                    end
                end
                ST_DATA_L: begin
                    if (take_s) acc_r <= acc_sum_s;
                end
                ST_WRITE: begin
                    // 12-bit address wraps 0xFFF -> 0x000 naturally
                    addr_r  <= addr_r + 12'd1;
                    count_r <= count_r - 13'd1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Idle counter: runs only while waiting for a mid-frame byte, holds in WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_r <= 32'd0;
        end else if (timed_s) begin
            if (take_s) idle_cnt_r <= 32'd0;
            else        idle_cnt_r <= idle_cnt_r + 32'd1;
        end else if (state_r == ST_WRITE) begin
            idle_cnt_r <= idle_cnt_r;
        end else begin
            idle_cnt_r <= 32'd0;
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 12'h000;
            mem_wdata_r <= 16'h0000;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s != ST_WRITE);
            mem_we_r    <= (state_next_s == ST_WRITE);
            cpu_reset_r <= (state_next_s != ST_DONE);
            done_r      <= (state_next_s == ST_DONE);
            error_r     <= (state_next_s == ST_ERROR);
            // Address/data are loaded only when a word completes, so they
            // hold their last values whenever mem_we is low.
            if ((state_r == ST_DATA_L) && take_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= {hi_r, in_data};
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

endmodule

// File: tb/tb_mu01_prog_loader.sv
// Self-checking bench for mu01_prog_loader: a driver sends directed frames,
// expected memory writes go into a scoreboard queue, and a monitor compares
// every mem_we pulse against it. Status flags are checked inline.
module tb_mu01_prog_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int tests;
    int failed;

    logic [27:0] exp_q[$];   // {addr, data}
    logic [7:0]  fq[$];      // frame bytes to send

    mu01_prog_loader #(
        .TIMEOUT_CYCLES(16),
        .HEADER_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            logic [27:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failed++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata, e[27:16], e[15:0]);
                end
            end
            chk("in_ready_during_write", {31'd0, in_ready}, 32'd0);
        end
    end

    // Send one byte, waiting (bounded) for in_ready; returns 1ns after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            tests++;
            failed++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame();
        while (fq.size() > 0) send_byte(fq.pop_front());
    endtask

    task automatic chk_status(input string name, input logic d, input logic e, input logic cr);
        chk({name, "_done"},      {31'd0, done},      {31'd0, d});
        chk({name, "_error"},     {31'd0, error},     {31'd0, e});
        chk({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
    endtask

    // Valid two-word frame used several times.
    task automatic load_frame1();
        exp_q.push_back({12'h000, 16'h807F});
        exp_q.push_back({12'h001, 16'hA001});
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h80, 8'h7F, 8'hA0, 8'h01};
        send_frame();
        chk_status("f1_before_csum", 1'b0, 1'b0, 1'b1);
        send_byte(8'h5E);
        chk_status("f1_after_csum", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  {20'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // Junk before header is ignored, then a valid load
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        chk_status("junk", 1'b0, 1'b0, 1'b1);
        load_frame1();

        // Bad checksum: writes still happen, then error
        exp_q.push_back({12'h000, 16'h807F});
        exp_q.push_back({12'h001, 16'hA001});
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h80, 8'h7F, 8'hA0, 8'h01, 8'h5F};
        send_frame();
        chk_status("bad_csum", 1'b0, 1'b1, 1'b1);

        // Header in ERROR restarts: flags clear the cycle after it
        send_byte(8'h33);
        chk_status("error_junk", 1'b0, 1'b1, 1'b1);
        load_frame1();

        // Wrap-around; bytes 0F+FF+00+02+11+11+22+22 = 0x176, so CSUM = 0x8A
        exp_q.push_back({12'hFFF, 16'h1111});
        exp_q.push_back({12'h000, 16'h2222});
        fq = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h8A};
        send_frame();
        chk_status("wrap", 1'b1, 1'b0, 1'b0);

        // Oversize count -> error right after CNT_L, no writes
        send_byte(8'hA5);
        chk_status("restart_from_done", 1'b0, 1'b0, 1'b1);
        fq = '{8'h00, 8'h00, 8'h10, 8'h01};
        send_frame();
        chk_status("oversize", 1'b0, 1'b1, 1'b1);

        // Zero count -> done with no writes
        fq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
        send_frame();
        chk_status("zero_cnt", 1'b1, 1'b0, 1'b0);

        // Timeout: error exactly 16 cycles after the ADDR_H byte is accepted
        send_byte(8'hA5);
        send_byte(8'h00);
        repeat (15) @(posedge clk);
        #1;
        chk("timeout_15_error", {31'd0, error}, 32'd0);
        @(posedge clk);
        #1;
        chk("timeout_16_error", {31'd0, error}, 32'd1);
        chk("timeout_16_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // Reset asserted while waiting for DATA_L
        exp_q.push_back({12'h000, 16'h807F});   // hmm: none expected; removed below
        void'(exp_q.pop_back());
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h80};
        send_frame();
        reset = 1'b1;
        #1;
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("midrst_mem_addr",  {20'd0, mem_addr},  32'd0);
        chk("midrst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk_status("midrst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_frame1();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1);
    end

endmodule
